// File: rtl/riscv_defines.sv
// Shared constants for the writeback tag-check block: exception cause codes,
// policy mask bit positions, violation counter width and FSM state encoding.
package riscv_defines;

   localparam logic [2:0] TAG_EXC_NONE    = 3'd0;
   localparam logic [2:0] TAG_EXC_JUMP    = 3'd1;
   localparam logic [2:0] TAG_EXC_ST_ADDR = 3'd2;
   localparam logic [2:0] TAG_EXC_ST_DATA = 3'd3;
   localparam logic [2:0] TAG_EXC_RF      = 3'd4;

   localparam int unsigned MASK_JUMP    = 0;
   localparam int unsigned MASK_ST_ADDR = 1;
   localparam int unsigned MASK_ST_DATA = 2;
   localparam int unsigned MASK_RF      = 3;

   localparam int unsigned VIOL_CNT_W = 16;

   typedef enum logic {
      TAG_IDLE = 1'b0,
      TAG_REQ  = 1'b1
   } tag_state_e;

endpackage

// File: rtl/riscv_tag_check_wb_if.sv
// EX/controller side signals of the writeback tag checker, grouped as one bus.
interface riscv_tag_check_wb_if;
   import riscv_defines::*;

   logic                  ex_valid_i;
   logic                  rf_wdata_tag_i;
   logic                  rf_we_tag_i;
   logic                  jump_target_tag_i;
   logic                  pc_enable_tag_i;
   logic                  store_data_tag_i;
   logic                  store_we_tag_i;
   logic                  rs1_tag_i;
   logic                  is_jump_i;
   logic                  is_store_i;
   logic [4:0]            rf_waddr_i;
   logic [3:0]            check_mask_i;
   logic                  exc_ack_i;
   logic                  cnt_clear_i;
   logic                  rf_tag_we_o;
   logic [4:0]            rf_tag_waddr_o;
   logic                  rf_tag_wdata_o;
   logic                  exc_req_o;
   logic [2:0]            exc_cause_o;
   logic                  stall_o;
   logic [VIOL_CNT_W-1:0] viol_cnt_o;

   modport master (
      output ex_valid_i, rf_wdata_tag_i, rf_we_tag_i, jump_target_tag_i, pc_enable_tag_i,
             store_data_tag_i, store_we_tag_i, rs1_tag_i, is_jump_i, is_store_i,
             rf_waddr_i, check_mask_i, exc_ack_i, cnt_clear_i,
      input  rf_tag_we_o, rf_tag_waddr_o, rf_tag_wdata_o, exc_req_o, exc_cause_o,
             stall_o, viol_cnt_o
   );

   modport slave (
      input  ex_valid_i, rf_wdata_tag_i, rf_we_tag_i, jump_target_tag_i, pc_enable_tag_i,
             store_data_tag_i, store_we_tag_i, rs1_tag_i, is_jump_i, is_store_i,
             rf_waddr_i, check_mask_i, exc_ack_i, cnt_clear_i,
      output rf_tag_we_o, rf_tag_waddr_o, rf_tag_wdata_o, exc_req_o, exc_cause_o,
             stall_o, viol_cnt_o
   );

endinterface

// File: rtl/riscv_tag_policy_check.sv
// Combinational tag policy: per-rule violation flags and the fixed-priority cause.
module riscv_tag_policy_check
   import riscv_defines::*;
(
   input  logic       ex_valid,
   input  logic       rf_wdata_tag,
   input  logic       rf_we_tag,
   input  logic       jump_target_tag,
   input  logic       pc_enable_tag,
   input  logic       store_data_tag,
   input  logic       store_we_tag,
   input  logic       rs1_tag,
   input  logic       is_jump,
   input  logic       is_store,
   input  logic [3:0] check_mask,
   output logic [3:0] viol,
   output logic [2:0] cause
);

   always_comb begin
      viol = 4'b0000;
      if (ex_valid) begin
         viol[MASK_JUMP]    = is_jump & pc_enable_tag & jump_target_tag & check_mask[MASK_JUMP];
         viol[MASK_ST_ADDR] = is_store & store_we_tag & rs1_tag & check_mask[MASK_ST_ADDR];
         viol[MASK_ST_DATA] = is_store & store_we_tag & store_data_tag & check_mask[MASK_ST_DATA];
         viol[MASK_RF]      = rf_we_tag & rf_wdata_tag & check_mask[MASK_RF];
      end
   end

   always_comb begin
      cause = TAG_EXC_NONE;
      if (viol[MASK_JUMP])         cause = TAG_EXC_JUMP;
      else if (viol[MASK_ST_ADDR]) cause = TAG_EXC_ST_ADDR;
      else if (viol[MASK_ST_DATA]) cause = TAG_EXC_ST_DATA;
      else if (viol[MASK_RF])      cause = TAG_EXC_RF;
   end

endmodule

// File: rtl/riscv_tag_check_wb.sv
// Writeback tag checker: raises a held security exception on a tag policy
// violation, counts violations, and forwards clean tag writes to the tag regfile.
//
// state    | meaning
// TAG_IDLE | accepting retiring instructions, tag writes flow through
// TAG_REQ  | exception requested, pipeline stalled until controller acks
module riscv_tag_check_wb
   import riscv_defines::*;
(
   input  logic                clk,
   input  logic                rst_n,
   riscv_tag_check_wb_if.slave bus
);

   localparam logic [VIOL_CNT_W-1:0] CNT_MAX = {VIOL_CNT_W{1'b1}};

   tag_state_e            state_q, state_d;
   logic [3:0]            viol;
   logic [2:0]            cause, cause_q;
   logic [VIOL_CNT_W-1:0] viol_cnt_q;
   logic                  tag_we_q, tag_wdata_q;
   logic [4:0]            tag_waddr_q;
   logic                  capture, any_viol, enter_req;

   riscv_tag_policy_check u_policy (
      .ex_valid        (bus.ex_valid_i),
      .rf_wdata_tag    (bus.rf_wdata_tag_i),
      .rf_we_tag       (bus.rf_we_tag_i),
      .jump_target_tag (bus.jump_target_tag_i),
      .pc_enable_tag   (bus.pc_enable_tag_i),
      .store_data_tag  (bus.store_data_tag_i),
      .store_we_tag    (bus.store_we_tag_i),
      .rs1_tag         (bus.rs1_tag_i),
      .is_jump         (bus.is_jump_i),
      .is_store        (bus.is_store_i),
      .check_mask      (bus.check_mask_i),
      .viol            (viol),
      .cause           (cause)
   );

   // Retiring instructions are only looked at while IDLE; in REQ the pipe is stalled.
   assign capture  = (state_q == TAG_IDLE) && bus.ex_valid_i;
   assign any_viol = |viol;

   always_comb begin
      state_d   = state_q;
      enter_req = 1'b0;
      case (state_q)
         TAG_IDLE: begin
            if (capture && any_viol) begin
               state_d   = TAG_REQ;
               enter_req = 1'b1;
            end
         end
         TAG_REQ: begin
            if (bus.exc_ack_i) state_d = TAG_IDLE;
         end
         default: state_d = TAG_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TAG_IDLE;
         cause_q <= TAG_EXC_NONE;
      end else begin
         state_q <= state_d;
         if (enter_req) cause_q <= cause;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_cnt_q <= '0;
      end else if (bus.cnt_clear_i) begin
         viol_cnt_q <= '0;
      end else if (enter_req && (viol_cnt_q != CNT_MAX)) begin
         viol_cnt_q <= viol_cnt_q + 1'b1;
      end
   end

   // x0 is hardwired, so its tag is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_we_q    <= 1'b0;
         tag_waddr_q <= 5'd0;
         tag_wdata_q <= 1'b0;
      end else begin
         tag_we_q <= capture && !any_viol && bus.rf_we_tag_i && (bus.rf_waddr_i != 5'd0);
         if (capture && !any_viol) begin
            tag_waddr_q <= bus.rf_waddr_i;
            tag_wdata_q <= bus.rf_wdata_tag_i;
         end
      end
   end

   assign bus.exc_req_o      = (state_q == TAG_REQ);
   assign bus.stall_o        = (state_q == TAG_REQ);
   assign bus.exc_cause_o    = (state_q == TAG_REQ) ? cause_q : TAG_EXC_NONE;
   assign bus.viol_cnt_o     = viol_cnt_q;
   assign bus.rf_tag_we_o    = tag_we_q;
   assign bus.rf_tag_waddr_o = tag_waddr_q;
   assign bus.rf_tag_wdata_o = tag_wdata_q;

endmodule

// File: tb/tb_riscv_tag_check_wb.sv
// Directed bench for riscv_tag_check_wb: a vector table of single retiring
// instructions plus hand-written stall, saturation, clear and reset sequences.
module tb_riscv_tag_check_wb;

   logic clk;
   logic rst_n;

   riscv_tag_check_wb_if bus ();

   riscv_tag_check_wb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       is_jump;
      logic       pc_en;
      logic       jt_tag;
      logic       is_store;
      logic       st_we;
      logic       rs1_tag;
      logic       sd_tag;
      logic       rf_we;
      logic       rf_wd;
      logic [4:0] waddr;
      logic [3:0] mask;
      logic [2:0] exp_cause;
      logic       exp_we;
   } vec_t;

   vec_t vecs[12];
   int   n_vec;
   int   n_err;
   int   cnt_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.ex_valid_i        = 1'b0;
      bus.rf_wdata_tag_i    = 1'b0;
      bus.rf_we_tag_i       = 1'b0;
      bus.jump_target_tag_i = 1'b0;
      bus.pc_enable_tag_i   = 1'b0;
      bus.store_data_tag_i  = 1'b0;
      bus.store_we_tag_i    = 1'b0;
      bus.rs1_tag_i         = 1'b0;
      bus.is_jump_i         = 1'b0;
      bus.is_store_i        = 1'b0;
      bus.rf_waddr_i        = 5'd0;
      bus.check_mask_i      = 4'h0;
   endtask

   task automatic drive_vec(input vec_t v);
      bus.ex_valid_i        = 1'b1;
      bus.is_jump_i         = v.is_jump;
      bus.pc_enable_tag_i   = v.pc_en;
      bus.jump_target_tag_i = v.jt_tag;
      bus.is_store_i        = v.is_store;
      bus.store_we_tag_i    = v.st_we;
      bus.rs1_tag_i         = v.rs1_tag;
      bus.store_data_tag_i  = v.sd_tag;
      bus.rf_we_tag_i       = v.rf_we;
      bus.rf_wdata_tag_i    = v.rf_wd;
      bus.rf_waddr_i        = v.waddr;
      bus.check_mask_i      = v.mask;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One jump violation from IDLE followed by an ack; expected count given by caller.
   task automatic jump_viol(input string name, input logic clr, input int exp_cnt);
      drive_vec('{1,1,1, 0,0,0,0, 0,0, 5'd1, 4'hF, 3'd1, 0});
      bus.cnt_clear_i = clr;
      step();
      idle_inputs();
      bus.cnt_clear_i = 1'b0;
      check({name, " req"}, 32'(bus.exc_req_o), 32'd1);
      check({name, " cnt"}, 32'(bus.viol_cnt_o), 32'(exp_cnt));
      bus.exc_ack_i = 1'b1;
      step();
      bus.exc_ack_i = 1'b0;
      check({name, " ack idle"}, 32'(bus.exc_req_o), 32'd0);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      cnt_exp = 0;

      //          jmp pce jt  st  swe rs1 sd  rfwe rfwd waddr  mask  cause we
      vecs[0]  = '{1, 1, 1,  0, 0, 0, 0,  0, 0,  5'd3,  4'hF, 3'd1, 0};
      vecs[1]  = '{1, 0, 1,  0, 0, 0, 0,  0, 0,  5'd3,  4'hF, 3'd0, 0};
      vecs[2]  = '{0, 0, 0,  1, 1, 1, 1,  0, 0,  5'd3,  4'hF, 3'd2, 0};
      vecs[3]  = '{0, 0, 0,  1, 1, 0, 1,  0, 0,  5'd3,  4'hF, 3'd3, 0};
      vecs[4]  = '{0, 0, 0,  1, 1, 1, 1,  0, 0,  5'd3,  4'hD, 3'd3, 0};
      vecs[5]  = '{0, 0, 0,  1, 0, 1, 1,  0, 0,  5'd3,  4'hF, 3'd0, 0};
      vecs[6]  = '{0, 0, 0,  0, 0, 0, 0,  1, 1,  5'd7,  4'hF, 3'd4, 0};
      vecs[7]  = '{0, 0, 0,  0, 0, 0, 0,  1, 0,  5'd9,  4'hF, 3'd0, 1};
      vecs[8]  = '{1, 1, 1,  1, 1, 1, 1,  1, 1,  5'd5,  4'h0, 3'd0, 1};
      vecs[9]  = '{0, 0, 0,  0, 0, 0, 0,  1, 1,  5'd0,  4'h7, 3'd0, 0};
      vecs[10] = '{1, 1, 1,  1, 1, 1, 1,  1, 1,  5'd4,  4'hF, 3'd1, 0};
      vecs[11] = '{1, 1, 1,  0, 0, 0, 0,  1, 1,  5'd4,  4'hE, 3'd4, 0};

      idle_inputs();
      bus.exc_ack_i   = 1'b0;
      bus.cnt_clear_i = 1'b0;
      rst_n = 1'b0;
      #12;
      check("reset req",   32'(bus.exc_req_o),      32'd0);
      check("reset cause", 32'(bus.exc_cause_o),    32'd0);
      check("reset stall", 32'(bus.stall_o),        32'd0);
      check("reset cnt",   32'(bus.viol_cnt_o),     32'd0);
      check("reset we",    32'(bus.rf_tag_we_o),    32'd0);
      check("reset waddr", 32'(bus.rf_tag_waddr_o), 32'd0);
      check("reset wdata", 32'(bus.rf_tag_wdata_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         drive_vec(vecs[i]);
         step();
         idle_inputs();
         if (vecs[i].exp_cause != 3'd0) cnt_exp++;
         check($sformatf("v%0d req", i),   32'(bus.exc_req_o),   32'(vecs[i].exp_cause != 3'd0));
         check($sformatf("v%0d stall", i), 32'(bus.stall_o),     32'(vecs[i].exp_cause != 3'd0));
         check($sformatf("v%0d cause", i), 32'(bus.exc_cause_o), 32'(vecs[i].exp_cause));
         check($sformatf("v%0d we", i),    32'(bus.rf_tag_we_o), 32'(vecs[i].exp_we));
         check($sformatf("v%0d cnt", i),   32'(bus.viol_cnt_o),  32'(cnt_exp));
         if (vecs[i].exp_we) begin
            check($sformatf("v%0d waddr", i), 32'(bus.rf_tag_waddr_o), 32'(vecs[i].waddr));
            check($sformatf("v%0d wdata", i), 32'(bus.rf_tag_wdata_o), 32'(vecs[i].rf_wd));
         end
         if (vecs[i].exp_cause != 3'd0) begin
            bus.exc_ack_i = 1'b1;
            step();
            bus.exc_ack_i = 1'b0;
            check($sformatf("v%0d ack req", i),   32'(bus.exc_req_o),   32'd0);
            check($sformatf("v%0d ack cause", i), 32'(bus.exc_cause_o), 32'd0);
         end else begin
            step();
            check($sformatf("v%0d we drop", i), 32'(bus.rf_tag_we_o), 32'd0);
         end
      end

      // ack while IDLE is ignored; ack held across a violation exits REQ one cycle later
      bus.exc_ack_i = 1'b1;
      step();
      check("idle ack req", 32'(bus.exc_req_o), 32'd0);
      drive_vec(vecs[0]);
      step();
      idle_inputs();
      cnt_exp++;
      check("ack held enter", 32'(bus.exc_req_o), 32'd1);
      step();
      bus.exc_ack_i = 1'b0;
      check("ack held exit", 32'(bus.exc_req_o), 32'd0);
      check("ack held cnt",  32'(bus.viol_cnt_o), 32'(cnt_exp));

      // RF violation, then retiring instructions during REQ must be ignored
      drive_vec(vecs[6]);
      step();
      cnt_exp++;
      check("rq cause", 32'(bus.exc_cause_o), 32'd4);
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive_vec(vecs[0]);
         else        drive_vec(vecs[7]);
         step();
         check($sformatf("rq%0d req", k),   32'(bus.exc_req_o),   32'd1);
         check($sformatf("rq%0d cause", k), 32'(bus.exc_cause_o), 32'd4);
         check($sformatf("rq%0d cnt", k),   32'(bus.viol_cnt_o),  32'(cnt_exp));
         check($sformatf("rq%0d we", k),    32'(bus.rf_tag_we_o), 32'd0);
      end
      idle_inputs();

      // asynchronous reset in the middle of REQ
      #2;
      rst_n = 1'b0;
      #1;
      check("mid rst req",   32'(bus.exc_req_o),      32'd0);
      check("mid rst cause", 32'(bus.exc_cause_o),    32'd0);
      check("mid rst stall", 32'(bus.stall_o),        32'd0);
      check("mid rst cnt",   32'(bus.viol_cnt_o),     32'd0);
      check("mid rst waddr", 32'(bus.rf_tag_waddr_o), 32'd0);
      check("mid rst wdata", 32'(bus.rf_tag_wdata_o), 32'd0);
      cnt_exp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      jump_viol("c1", 1'b0, 1);
      jump_viol("c2", 1'b0, 2);
      jump_viol("clr", 1'b1, 0);

      // saturation: preload near full scale rather than spending 64k violations
      dut.viol_cnt_q = 16'hFFFD;
      jump_viol("sat1", 1'b0, 16'hFFFE);
      jump_viol("sat2", 1'b0, 16'hFFFF);
      jump_viol("sat3", 1'b0, 16'hFFFF);
      jump_viol("sat clr", 1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_tag_check_wb.md
RISCV_TAG_CHECK_WB -- requirements
Module: riscv_tag_check_wb

Interface
REQ-001 SHALL have clk  in  1  core clock.
REQ-002 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ex_valid_i  in  1  EX stage retires an instruction into WB this cycle.
REQ-004 SHALL have rf_wdata_tag_i, rf_we_tag_i  in  1 each  EX result tag and tag write enable.
REQ-005 SHALL have jump_target_tag_i, pc_enable_tag_i  in  1 each  jump-target tag and PC-tag update enable.
REQ-006 SHALL have store_data_tag_i, store_we_tag_i, rs1_tag_i  in  1 each  store-data tag, store tag enable, base-address tag.
REQ-007 SHALL have is_jump_i, is_store_i  in  1 each  instruction class qualifiers.
REQ-008 SHALL have rf_waddr_i  in  5  destination register of the retiring instruction.
REQ-009 SHALL have check_mask_i  in  4  policy enables: bit0 jump, bit1 store-address, bit2 store-data, bit3 register-write.
REQ-010 SHALL have exc_ack_i  in  1  controller accepted the security exception.
REQ-011 SHALL have cnt_clear_i  in  1  synchronous clear of the violation counter.
REQ-012 SHALL have rf_tag_we_o, rf_tag_waddr_o (5), rf_tag_wdata_o (1)  out  registered tag-regfile write port.
REQ-013 SHALL have exc_req_o  out  1, exc_cause_o  out  3, stall_o  out  1, viol_cnt_o  out  16.

Function
REQ-014 SHALL evaluate violations combinationally on inputs only when ex_valid_i=1: V0=jump&pc_enable&jump_target_tag&mask0; V1=is_store&store_we_tag&rs1_tag&mask1; V2=is_store&store_we_tag&store_data_tag&mask2; V3=rf_we_tag&rf_wdata_tag&mask3.
REQ-015 SHALL select cause by fixed priority V0>V1>V2>V3, encoded 1,2,3,4; 0 = none.
REQ-016 SHALL implement FSM IDLE, REQ: IDLE->REQ at the edge where ex_valid_i=1 and any V set; REQ->IDLE at the edge where exc_ack_i=1.
REQ-017 SHALL assert exc_req_o and stall_o exactly while in REQ; exc_cause_o SHALL hold the latched cause in REQ and read 0 in IDLE.
REQ-018 SHALL ignore ex_valid_i while in REQ (no capture, no count, no tag write); exc_ack_i in IDLE SHALL be ignored.
REQ-019 SHALL, at each edge with ex_valid_i=1 in IDLE and no violation, register rf_tag_we_o=rf_we_tag_i, rf_tag_waddr_o=rf_waddr_i, rf_tag_wdata_o=rf_wdata_tag_i (one-cycle latency); otherwise rf_tag_we_o SHALL be 0 next cycle.
REQ-020 SHALL suppress the tag write for a violating instruction (rf_tag_we_o=0).
REQ-021 SHALL increment viol_cnt_o by 1 on each IDLE->REQ transition, saturating at 0xFFFF.
REQ-022 SHALL give cnt_clear_i priority over a same-cycle increment (counter reads 0 next cycle).
REQ-023 SHALL suppress writes to x0 (rf_waddr_i=0 forces rf_tag_we_o=0).

Reset
REQ-024 SHALL, on rst_n low at any time including mid-REQ, force FSM=IDLE, exc_req_o=0, exc_cause_o=0, stall_o=0, viol_cnt_o=0, rf_tag_we_o=0, rf_tag_waddr_o=0, rf_tag_wdata_o=0.

Structure
REQ-025 SHALL place cause codes (TAG_EXC_NONE/JUMP/ST_ADDR/ST_DATA/RF = 0..4), mask bit indices and counter width constant in riscv_defines.
REQ-026 SHALL contain one combinational sub-module riscv_tag_policy_check producing V[3:0] and the encoded cause; FSM, counter and tag write register stay in the top.

Verification
REQ-027 SHALL cover: mask=4'hF, ex_valid, is_jump, pc_enable=1, jump_target_tag=1 -> next cycle exc_req_o=1, cause=1, stall_o=1, viol_cnt_o=1; ack -> IDLE next cycle.
REQ-028 SHALL cover: store with rs1_tag=1 and store_data_tag=1 simultaneously -> cause=2, count +1 only.
REQ-029 SHALL cover: mask=0, all tags=1, rf_waddr=5 -> no exc_req_o, rf_tag_we_o=1, waddr=5, wdata=1 one cycle later.
REQ-030 SHALL cover: counter preloaded to 0xFFFF via 65535 violations -> further violation leaves 0xFFFF; cnt_clear_i with violation same cycle -> 0.
REQ-031 SHALL cover: rst_n asserted while in REQ with cause=4 -> all outputs 0 immediately; ex_valid_i during REQ -> no tag write, no count.
